// File: rtl/serial_arbiter.sv
// -----------------------------------------------------------------------------
// serial_arbiter
//
// Round-robin arbiter that shares one 32-bit serial transmitter among N_REQ
// requesters. A winning requester's word is captured, handed to the
// transmitter with a one-cycle load_data pulse, and the arbiter then waits for
// tran_done before pulsing that requester's done bit. A watchdog aborts the
// wait if tran_done never arrives. The abort sets a sticky timeout_err flag.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  sclk cycles allowed in WAIT before abort (> 34)
//
// Ports
//   sclk         in   serial clock, rising-edge active
//   rst_n        in   asynchronous active-low reset
//   req          in   level request per requester
//   req_data     in   word for requester k on bits [32k+31:32k]
//   ack          out  one-cycle pulse: request accepted, data captured
//   done         out  one-cycle pulse: requester's word fully shifted out
//   load_data    out  load strobe to the transmitter
//   data_out     out  captured word to the transmitter
//   tran_done    in   end-of-frame strobe from the transmitter
//   busy         out  high whenever the arbiter is not idle
//   timeout_err  out  sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module serial_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      done,
    output logic                  load_data,
    output logic [31:0]           data_out,
    input  logic                  tran_done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Next requester index, wrapping at N_REQ (not necessarily a power of two).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        if (v == IW'(N_REQ - 1)) begin
            r = '0;
        end else begin
            r = v + IW'(1);
        end
        return r;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] one_hot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (idx == IW'(k)) begin
                v[k] = 1'b1;
            end else begin
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    logic [1:0]        state_r, state_nxt_s;
    logic [IW-1:0]     ptr_r, ptr_nxt_s;
    logic [IW-1:0]     g_r, g_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic [31:0]       data_r, data_nxt_s;
    logic              terr_r, terr_nxt_s;
    logic [N_REQ-1:0]  ack_r, ack_nxt_s;
    logic [N_REQ-1:0]  done_r, done_nxt_s;
    logic              load_r, load_nxt_s;
    logic              busy_r, busy_nxt_s;

    logic [IW-1:0]     cand_s;
    logic [IW-1:0]     win_idx_s;
    logic              win_found_s;
    logic [31:0]       sel_data_s;

    // Round-robin scan: first set request at or after ptr, wrapping around.
    always_comb begin
        cand_s      = ptr_r;
        win_idx_s   = ptr_r;
        win_found_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
            cand_s = wrap_inc(cand_s);
        end
    end

    // Select the winning requester's word.
    always_comb begin
        sel_data_s = 32'h0000_0000;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx_s == IW'(k)) begin
                sel_data_s = req_data[32*k +: 32];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state and next-output decode; every output is registered from here.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        g_nxt_s     = g_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        terr_nxt_s  = terr_r;
        ack_nxt_s   = '0;
        done_nxt_s  = '0;
        load_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = ST_LOAD;
                    g_nxt_s     = win_idx_s;
                    data_nxt_s  = sel_data_s;
                    ack_nxt_s   = one_hot(win_idx_s);
                    load_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_WAIT;
                cnt_nxt_s   = '0;
            end
            ST_WAIT: begin
                // tran_done has priority over a watchdog expiry in the same cycle.
                if (tran_done) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = one_hot(g_r);
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    state_nxt_s = ST_IDLE;
                    terr_nxt_s  = 1'b1;
                    ptr_nxt_s   = wrap_inc(g_r);
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = wrap_inc(g_r);
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            g_r     <= '0;
            cnt_r   <= '0;
            data_r  <= 32'h0000_0000;
            terr_r  <= 1'b0;
            ack_r   <= '0;
            done_r  <= '0;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            g_r     <= g_nxt_s;
            cnt_r   <= cnt_nxt_s;
            data_r  <= data_nxt_s;
            terr_r  <= terr_nxt_s;
            ack_r   <= ack_nxt_s;
            done_r  <= done_nxt_s;
            load_r  <= load_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign ack         = ack_r;
    assign done        = done_r;
    assign load_data   = load_r;
    assign data_out    = data_r;
    assign busy        = busy_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_serial_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_arbiter
//
// Self-checking bench for serial_arbiter. A transaction-level reference model
// tracks the round-robin pointer and the sticky watchdog flag; the bench plays
// the transmitter by returning tran_done after a chosen number of WAIT cycles
// (or never).
// -----------------------------------------------------------------------------
module tb_serial_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 40;

    logic                 sclk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req;
    logic [32*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]     ack;
    logic [N_REQ-1:0]     done;
    logic                 load_data;
    logic [31:0]          data_out;
    logic                 tran_done;
    logic                 busy;
    logic                 timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;
    bit exp_terr  = 1'b0;

    serial_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .load_data   (load_data),
        .data_out    (data_out),
        .tran_done   (tran_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int model_winner(input logic [N_REQ-1:0] r);
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (model_ptr + i) % N_REQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [32*N_REQ-1:0] rand_words();
        logic [32*N_REQ-1:0] d;
        for (int k = 0; k < N_REQ; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    // One arbitration round. tdone_at = WAIT cycle (0-based) in which tran_done
    // is high; any value outside 0..TIMEOUT-1 means tran_done never comes.
    task automatic run_txn(input logic [N_REQ-1:0] r, input logic [32*N_REQ-1:0] d,
                           input int tdone_at, input bit hold);
        int          g;
        logic [31:0] exp_oh;
        logic [31:0] exp_data;
        bit          fired;
        @(negedge sclk);
        req      = r;
        req_data = d;
        g        = model_winner(r);
        exp_oh   = 32'd1 << g;
        exp_data = d[32*g +: 32];
        @(posedge sclk); #1;
        check_val("load_ack",  32'(ack),       exp_oh);
        check_val("load_strb", 32'(load_data), 32'd1);
        check_val("load_busy", 32'(busy),      32'd1);
        check_val("load_data", data_out,       exp_data);
        check_val("load_done", 32'(done),      32'd0);
        if (!hold) req = '0;
        @(posedge sclk); #1;
        fired = 1'b0;
        for (int i = 0; i < TIMEOUT && !fired; i++) begin
            check_val("wait_strb", 32'(load_data), 32'd0);
            check_val("wait_ack",  32'(ack),       32'd0);
            check_val("wait_done", 32'(done),      32'd0);
            check_val("wait_busy", 32'(busy),      32'd1);
            if (i == tdone_at) begin
                tran_done = 1'b1;
                fired     = 1'b1;
            end
            @(posedge sclk); #1;
            tran_done = 1'b0;
        end
        if (fired) begin
            check_val("done_pulse", 32'(done),        exp_oh);
            check_val("done_busy",  32'(busy),        32'd1);
            check_val("done_terr",  32'(timeout_err), 32'(exp_terr));
            @(posedge sclk); #1;
        end else begin
            exp_terr = 1'b1;
        end
        model_ptr = (g + 1) % N_REQ;
        check_val("idle_busy", 32'(busy),        32'd0);
        check_val("idle_done", 32'(done),        32'd0);
        check_val("idle_terr", 32'(timeout_err), 32'(exp_terr));
        check_val("idle_hold", data_out,         exp_data);
    endtask

    initial begin
        int g;
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        tran_done = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check_val("rst_ack",  32'(ack),         32'd0);
        check_val("rst_done", 32'(done),        32'd0);
        check_val("rst_strb", 32'(load_data),   32'd0);
        check_val("rst_busy", 32'(busy),        32'd0);
        check_val("rst_terr", 32'(timeout_err), 32'd0);
        check_val("rst_data", data_out,         32'd0);
        @(negedge sclk);
        rst_n = 1'b1;

        // No request: arbiter stays idle.
        repeat (3) begin
            @(posedge sclk); #1;
            check_val("noreq_busy", 32'(busy), 32'd0);
            check_val("noreq_ack",  32'(ack),  32'd0);
        end

        // All requesting, held: grants 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            check_val("rr_order", 32'(model_winner(4'b1111)), 32'(n % N_REQ));
            run_txn(4'b1111, rand_words(), 32, (n != 4));
        end

        // Wrap and fairness: grant 3, then 1001 gives 0 then 3.
        run_txn(4'b1000, rand_words(), 33, 1'b0);
        check_val("wrap_first",  32'(model_winner(4'b1001)), 32'd0);
        run_txn(4'b1001, rand_words(), 33, 1'b0);
        check_val("wrap_second", 32'(model_winner(4'b1001)), 32'd3);
        run_txn(4'b1001, rand_words(), 33, 1'b0);

        // Single request with a known word.
        run_txn(4'b0001, {96'h0, 32'hA5A5_0F0F}, 32, 1'b0);

        // Tie: tran_done on the very cycle the watchdog would expire.
        run_txn(4'b0100, rand_words(), TIMEOUT - 1, 1'b0);

        // Watchdog: tran_done never arrives; next grant resumes after 1.
        run_txn(4'b0010, rand_words(), -1, 1'b0);
        check_val("wd_ptr", 32'(model_ptr), 32'd2);
        run_txn(4'b1111, rand_words(), 32, 1'b0);

        // Randomized rounds, including occasional watchdog expiries.
        for (int n = 0; n < 30; n++) begin
            int dly;
            dly = $urandom_range(20, 45);
            run_txn(4'($urandom_range(1, 15)), rand_words(), dly, 1'($urandom_range(0, 1)));
        end
        @(negedge sclk);
        req = '0;

        // Reset mid-transfer, then a stale tran_done in IDLE.
        @(negedge sclk);
        req      = 4'b0001;
        req_data = rand_words();
        @(posedge sclk); #1;
        req = '0;
        repeat (5) @(posedge sclk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mrst_ack",  32'(ack),         32'd0);
        check_val("mrst_done", 32'(done),        32'd0);
        check_val("mrst_strb", 32'(load_data),   32'd0);
        check_val("mrst_busy", 32'(busy),        32'd0);
        check_val("mrst_terr", 32'(timeout_err), 32'd0);
        check_val("mrst_data", data_out,         32'd0);
        exp_terr  = 1'b0;
        model_ptr = 0;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        @(posedge sclk); #1;
        tran_done = 1'b1;
        @(posedge sclk); #1;
        tran_done = 1'b0;
        check_val("stale_busy", 32'(busy), 32'd0);
        check_val("stale_done", 32'(done), 32'd0);
        @(posedge sclk); #1;
        check_val("stale_done2", 32'(done), 32'd0);
        g = model_winner(4'b0100);
        check_val("post_rst_grant", 32'(g), 32'd2);
        run_txn(4'b0100, rand_words(), 32, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
